// File: rtl/hs_npu_pkg.sv
// Shared AXI definitions for the NPU on-chip memory slave.
// Holds response/burst encodings, the fixed beat size and the channel FSM
// state types, plus a helper that flags unsupported request attributes.
package hs_npu_pkg;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Only 4-byte beats with FIXED or INCR bursts are supported; WRAP and the
  // reserved encoding are still walked as INCR but answered with SLVERR.
  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_4B) || (burst == AXI_BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/hs_npu_axi_burst_addr.sv
// Burst address helper, one instance per channel.
//   addr      : byte address of the beat being examined
//   burst     : AXI burst type of the transaction
//   beat      : beat handshake; advances next_addr when set
//   next_addr : address of the following beat (FIXED holds, others +4)
//   in_range  : addr maps onto the array
//   idx       : word index of addr into the array
module hs_npu_axi_burst_addr
  import hs_npu_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          IDX_W     = $clog2(DEPTH)
) (
  input  logic [31:0]      addr,
  input  logic [1:0]       burst,
  input  logic             beat,
  output logic [31:0]      next_addr,
  output logic             in_range,
  output logic [IDX_W-1:0] idx
);

  logic [31:0] off;
  logic        unused_lsb;

  assign off        = addr - BASE_ADDR;
  assign unused_lsb = ^off[1:0];
  // Full-width compare: addresses past the array are errors, never aliased.
  assign in_range   = (addr >= BASE_ADDR) && ({2'b00, off[31:2]} < 32'(DEPTH));
  assign idx        = off[IDX_W+1:2];
  assign next_addr  = (beat && (burst != AXI_BURST_FIXED)) ? addr + 32'd4 : addr;

endmodule

// File: rtl/hs_npu_axi_mem_slave.sv
// AXI4 burst responder backed by a word-addressed on-chip array.
// Independent read and write channels, one outstanding transaction each.
//   clk/rst        : clock, synchronous active-high reset
//   aw*/w*/b*      : write address, data and response channels
//   ar*/r*         : read address and data channels
// Read data is registered; the array is read combinationally into rdata_q so
// a same-cycle write to the same word is seen as old data by the read.
module hs_npu_axi_mem_slave
  import hs_npu_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ID_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            awready,
  input  logic            awvalid,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [31:0]     awaddr,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [2:0]      awprot,
  output logic            wready,
  input  logic            wvalid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            bready,
  output logic            bvalid,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            arready,
  input  logic            arvalid,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [31:0]     araddr,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [2:0]      arprot,
  input  logic            rready,
  output logic            rvalid,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // ---------------- write channel ----------------
  wr_state_t        w_state_q, w_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [7:0]       w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [31:0]      w_addr_q, w_addr_d, w_next_addr;
  logic [1:0]       w_burst_q, w_burst_d;
  logic             w_err_q, w_err_d, w_in_range, mem_we;
  logic [IDX_W-1:0] w_idx;

  hs_npu_axi_burst_addr #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_waddr (
    .addr(w_addr_q), .burst(w_burst_q), .beat(wvalid & wready),
    .next_addr(w_next_addr), .in_range(w_in_range), .idx(w_idx)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_addr_d  = w_addr_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          w_id_d    = awid;
          w_len_d   = awlen;
          w_addr_d  = awaddr;
          w_burst_d = awburst;
          w_err_d   = req_bad(awsize, awburst);
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          // Once flagged, the remaining beats are consumed but not stored.
          mem_we   = w_in_range & ~w_err_q;
          if (!w_in_range || (wlast != (w_cnt_q == w_len_q))) w_err_d = 1'b1;
          w_addr_d = w_next_addr;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
          else                    w_cnt_d   = w_cnt_q + 8'd1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign bid   = w_id_q;
  assign bresp = (w_state_q == W_RESP && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  // r_addr_q points at the next beat to fetch, so one address helper serves
  // both the first fetch (from araddr) and every following one.
  rd_state_t        r_state_q, r_state_d;
  logic [ID_W-1:0]  r_id_q, r_id_d;
  logic [7:0]       r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [31:0]      r_addr_q, r_addr_d, r_next_addr, r_addr_in;
  logic [1:0]       r_burst_q, r_burst_d, r_burst_in;
  logic             r_err_q, r_err_d, r_in_range, r_bad, r_beat;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      rdata_q, rdata_d, rd_word;
  axi_resp_t        rresp_q, rresp_d;
  logic             rlast_q, rlast_d;

  assign r_addr_in  = (r_state_q == R_IDLE) ? araddr  : r_addr_q;
  assign r_burst_in = (r_state_q == R_IDLE) ? arburst : r_burst_q;
  assign r_beat     = (r_state_q == R_IDLE) ? arvalid : rready;
  assign rd_word    = mem_q[r_idx];
  assign r_bad      = req_bad(arsize, arburst);

  hs_npu_axi_burst_addr #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_raddr (
    .addr(r_addr_in), .burst(r_burst_in), .beat(r_beat),
    .next_addr(r_next_addr), .in_range(r_in_range), .idx(r_idx)
  );

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    arready   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_id_d    = arid;
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_err_d   = r_bad;
          r_cnt_d   = 8'd0;
          r_addr_d  = r_next_addr;
          rdata_d   = r_in_range ? rd_word : 32'd0;
          rresp_d   = (r_bad || !r_in_range) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rlast_d   = (arlen == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_cnt_q == r_len_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_next_addr;
            rdata_d  = r_in_range ? rd_word : 32'd0;
            rresp_d  = (r_err_q || !r_in_range) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign rvalid = (r_state_q == R_DATA);
  assign rid    = r_id_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_addr_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_addr_q  <= w_addr_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

endmodule

// File: tb/tb_hs_npu_axi_mem_slave.sv
// Directed bench for hs_npu_axi_mem_slave: a byte-level memory model predicts
// read beats and write responses, which are queued when a request is issued
// and popped as the DUT answers.
module tb_hs_npu_axi_mem_slave;

  localparam int DEPTH = 4096;
  localparam int ID_W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic awready, awvalid, wready, wvalid, wlast, bready, bvalid;
  logic arready, arvalid, rready, rvalid, rlast;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;

  hs_npu_axi_mem_slave #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awready(awready), .awvalid(awvalid), .awid(awid), .awlen(awlen), .awaddr(awaddr),
    .awsize(awsize), .awburst(awburst), .awprot(awprot),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp),
    .arready(arready), .arvalid(arvalid), .arid(arid), .arlen(arlen), .araddr(araddr),
    .arsize(arsize), .arburst(arburst), .arprot(arprot),
    .rready(rready), .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [int];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(4 * DEPTH);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    int i;
    i = int'(a >> 2);
    return model.exists(i) ? model[i] : 32'h0;
  endfunction

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                          input logic [3:0] strb, input int last_at);
    logic err;
    logic [31:0] a, w;
    int t;
    bexp_t e;
    err = (size != 3'd2) || burst[1];
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    t = 0;
    while (!awready && t < 50) begin tick(); t++; end
    chk("aw_wait", 64'(t < 50), 64'd1);
    tick();
    awvalid = 1'b0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = d0 + 32'(i); wstrb = strb; wlast = (i == last_at);
      t = 0;
      while (!wready && t < 50) begin tick(); t++; end
      chk("w_wait", 64'(t < 50), 64'd1);
      if (in_rng(a) && !err) begin
        w = mdl_rd(a);
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[int'(a >> 2)] = w;
      end
      if (!in_rng(a) || ((i == last_at) != (i == int'(len)))) err = 1'b1;
      if (burst != 2'b00) a = a + 32'd4;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_ready_done", 64'(wready), 64'd0);
    bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin tick(); t++; end
    chk("b_wait", 64'(t < 50), 64'd1);
    e = bq.pop_front();
    chk("bid", 64'(bid), 64'(e.id));
    chk("bresp", 64'(bresp), 64'(e.resp));
    tick();
    bready = 1'b0;
    chk("awready_after_b", 64'(awready), 64'd1);
  endtask

  task automatic rd_start(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic err;
    logic [31:0] a;
    int t;
    err = (size != 3'd2) || burst[1];
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{id: id, data: in_rng(a) ? mdl_rd(a) : 32'h0,
                     resp: (err || !in_rng(a)) ? 2'b10 : 2'b00, last: (i == int'(len))});
      if (burst != 2'b00) a = a + 32'd4;
    end
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    chk("ar_wait", 64'(t < 50), 64'd1);
    tick();
    arvalid = 1'b0;
    chk("r_latency1", 64'(rvalid), 64'd1);
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating
  task automatic rd_collect(input int nbeats, input int mode);
    int got, cyc;
    logic stalled;
    logic [31:0] held;
    rexp_t e;
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < nbeats && cyc < 2000) begin
      rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (stalled) chk("r_stable", 64'(rdata), 64'(held));
      if (mode == 0) chk("r_b2b_valid", 64'(rvalid), 64'd1);
      if (rvalid && rready) begin
        e = rq.pop_front();
        chk("rdata", 64'(rdata), 64'(e.data));
        chk("rresp", 64'(rresp), 64'(e.resp));
        chk("rlast", 64'(rlast), 64'(e.last));
        chk("rid", 64'(rid), 64'(e.id));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = rvalid;
        held = rdata;
      end
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("r_beats", 64'(got), 64'(nbeats));
  endtask

  task automatic rd_end();
    chk("r_done_valid", 64'(rvalid), 64'd0);
    chk("r_done_arready", 64'(arready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awid = 0; awlen = 0; awaddr = 0; awsize = 0; awburst = 0; awprot = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; arlen = 0; araddr = 0; arsize = 0; arburst = 0; arprot = 0;
    rready = 0;
    tick(); tick();
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rlast",   64'(rlast),   64'd0);
    chk("rst_ids",     64'({bid, rid}), 64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_resps",   64'({bresp, rresp}), 64'd0);
    rst = 1'b0;
    tick();

    // INCR write then read back
    do_write(8'h05, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 3);
    rd_start(8'h07, 32'h10, 8'd3, 3'd2, 2'b01);
    rd_collect(4, 0);
    rd_end();

    // byte strobes
    do_write(8'h01, 32'h20, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 0);
    do_write(8'h02, 32'h20, 8'd0, 3'd2, 2'b01, 32'h0000_5500, 4'b0010, 0);
    chk("strobe_model", 64'(mdl_rd(32'h20)), 64'hDEAD55EF);
    rd_start(8'h03, 32'h20, 8'd0, 3'd2, 2'b01);
    rd_collect(1, 0);
    rd_end();

    // top-of-array boundary: in range, then out of range
    do_write(8'h11, 32'(4 * DEPTH - 4), 8'd1, 3'd2, 2'b01, 32'h12345678, 4'hF, 1);
    rd_start(8'h12, 32'(4 * DEPTH - 4), 8'd1, 3'd2, 2'b01);
    rd_collect(2, 0);
    rd_end();

    // stalled read of 8 beats
    do_write(8'h21, 32'h100, 8'd7, 3'd2, 2'b01, 32'hC0, 4'hF, 7);
    rd_start(8'h22, 32'h100, 8'd7, 3'd2, 2'b01);
    rd_collect(8, 1);
    rd_end();

    // protocol errors: early wlast, bad size, WRAP
    do_write(8'h31, 32'h200, 8'd2, 3'd2, 2'b01, 32'h77, 4'hF, 1);
    do_write(8'h32, 32'h40, 8'd0, 3'd2, 2'b01, 32'h11223344, 4'hF, 0);
    do_write(8'h33, 32'h40, 8'd0, 3'd1, 2'b01, 32'h55667788, 4'hF, 0);
    do_write(8'h34, 32'h60, 8'd0, 3'd2, 2'b10, 32'h99, 4'hF, 0);
    rd_start(8'h35, 32'h40, 8'd0, 3'd2, 2'b01);
    rd_collect(1, 0);
    rd_end();
    rd_start(8'h36, 32'h10, 8'd1, 3'd2, 2'b10);
    rd_collect(2, 0);
    rd_end();

    // FIXED bursts
    do_write(8'h41, 32'h80, 8'd3, 3'd2, 2'b00, 32'hB0, 4'hF, 3);
    rd_start(8'h42, 32'h80, 8'd1, 3'd2, 2'b00);
    rd_collect(2, 0);
    rd_end();

    // reset in the middle of a 16-beat read
    do_write(8'h51, 32'h300, 8'd15, 3'd2, 2'b01, 32'hE0, 4'hF, 15);
    rd_start(8'h52, 32'h300, 8'd15, 3'd2, 2'b01);
    rd_collect(5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_rvalid",  64'(rvalid),  64'd0);
    chk("midrst_arready", 64'(arready), 64'd1);
    rq.delete();
    rd_start(8'h53, 32'h300, 8'd15, 3'd2, 2'b01);
    rd_collect(16, 0);
    rd_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
